muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 160 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply, restoring divide,
// sign correction and a one-cycle done pulse beside the single-cycle ALU.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {high, low} or {rem, quo}
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, done_q;

  // Accept-time decode of signedness, magnitudes and special cases.
  logic             a_signed, b_signed, neg_a, neg_b, is_div, div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;

  always_comb begin
    a_signed    = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                  (Funct3 == 3'b100) || (Funct3 == 3'b110);
    b_signed    = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    neg_a       = a_signed && SrcA[WIDTH-1];
    neg_b       = b_signed && SrcB[WIDTH-1];
    a_mag       = neg_a ? -SrcA : SrcA;
    b_mag       = neg_b ? -SrcB : SrcB;
    is_div      = Funct3[2];
    div_zero    = is_div && (SrcB == '0);
    div_ovf     = is_div && !Funct3[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (SrcB == '1);
    // Overflow DIV returns the dividend itself (the most negative value).
    if (div_zero) special_res = Funct3[1] ? SrcA : '1;
    else          special_res = Funct3[1] ? '0 : SrcA;
  end

  // One iteration of each algorithm, plus the sign-corrected final values.
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff, div_rem, quo_fix, rem_fix, fix_res;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic               div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    // When the trial succeeds the difference is below the divisor, so WIDTH bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_fix   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (op_q[2])              fix_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q == 3'b000)  fix_res = prod_fix[WIDTH-1:0];
    else                      fix_res = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    // NOTE: every signal driven here gets a hold default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = Funct3;
          sa_d = neg_a;
          sb_d = neg_b;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_ITER;
            if (is_div) begin
              opnd_d = b_mag;
              acc_d  = {{WIDTH{1'b0}}, a_mag};
            end else begin
              opnd_d = a_mag;
              acc_d  = {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
      end
      S_ITER: begin
        acc_d = op_q[2] ? div_next : mul_next;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort leaves Result untouched, including a special-case write in the same cycle.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= (state_d == S_ITER) || (state_d == S_FIX);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic reference model with a
// latency timeline, a per-cycle compare process, directed literal cases and random traffic.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        busy, done;
  logic [31:0] Result;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'h0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    int sa, sb;
    xa = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'h0, a};
    xb = (f == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = xa * xb;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'b000:                 return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Timeline model: cycles since accept, total latency 34 (normal) or 1 (special).
  int          m_cyc = 0;
  int          m_lat = 34;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = 32'h0;
  logic [31:0] m_pend = 32'h0;
  logic        cmp_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_cyc    = 0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_result = 32'h0;
    end else begin
      if (flush)               m_cyc = 0;
      else if (m_cyc == 0) begin
        if (start) begin
          m_cyc  = 1;
          m_lat  = is_special(Funct3, SrcA, SrcB) ? 1 : 34;
          m_pend = ref_res(Funct3, SrcA, SrcB);
        end
      end
      else if (m_cyc == m_lat) m_cyc = 0;
      else                     m_cyc++;
      m_busy = (m_cyc != 0) && (m_lat == 34) && (m_cyc < 34);
      m_done = (m_cyc != 0) && (m_cyc == m_lat);
      if (m_done) m_result = m_pend;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("Result", Result, m_result);
    end
  end

  // Issue one op from IDLE, change operands mid-ITER, and check latency plus literal result.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k;
    @(negedge clk);
    start  = 1'b1;
    Funct3 = f;
    SrcA   = a;
    SrcB   = b;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 3) begin
        SrcA = ~a;
        SrcB = b ^ 32'h5;
      end
      if (done) begin
        k = i;
        break;
      end
    end
    start = 1'b0;
    check({nm, " latency"}, 32'(k), 32'(lat));
    check(nm, Result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int d1, d2;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    Funct3 = 3'b000; SrcA = 32'h0; SrcB = 32'h0;
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset Result", Result, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    check("model MULH", ref_res(3'b001, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("model REM", ref_res(3'b110, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);

    run_op("MUL",    3'b000, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("DIV",    3'b100, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 34);
    run_op("REM",    3'b110, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34);
    run_op("DIVU",   3'b101, 32'd100,       32'd7,         32'd14,        34);
    run_op("REMU",   3'b111, 32'd100,       32'd7,         32'd2,         34);
    run_op("DIVU/0", 3'b101, 32'd5,         32'h0,         32'hFFFF_FFFF, 1);
    run_op("REM/0",  3'b110, 32'd5,         32'h0,         32'd5,         1);
    run_op("DIVovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REMovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

    // Flush at N+10 of a DIV, then a MUL 3x4 accepted at N+11.
    @(negedge clk);
    start = 1'b1; Funct3 = 3'b100; SrcA = 32'd1000; SrcB = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'h0);
    check("flush Result kept", Result, 32'h0);
    Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd4;
    d1 = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done) begin
        d1 = i;
        break;
      end
    end
    start = 1'b0;
    check("post-flush MUL latency", 32'(d1), 32'd34);
    check("post-flush MUL", Result, 32'd12);

    // Back-to-back MULs with start held high.
    @(negedge clk);
    start = 1'b1; Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd11;
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = i;
        else begin
          d2 = i;
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b first done", 32'(d1), 32'd34);
    check("b2b second done", 32'(d2), 32'd69);
    check("b2b Result", Result, 32'd99);

    // Reset at N+20 of a MUL.
    @(negedge clk);
    start = 1'b1; Funct3 = 3'b011; SrcA = 32'h1234_5678; SrcB = 32'h9ABC_DEF0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("midop reset busy", 32'(busy), 32'h0);
    check("midop reset done", 32'(done), 32'h0);
    check("midop reset Result", Result, 32'h0);
    reset = 1'b0;

    // Random traffic: held/pulsed start, flushes, rare resets, operands changing every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 499) == 0);
      flush  = ($urandom_range(0, 59) == 0);
      start  = ($urandom_range(0, 9) < 7);
      Funct3 = 3'($urandom_range(0, 7));
      SrcA   = pick();
      SrcB   = pick();
    end
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
